// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size encodings, arbiter FSM states and the CPU alignment rule
// shared by the data-memory arbiter and the load/store unit.
package dmem_pkg;
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b11;
  typedef enum logic {ST_CPU_PRIO = 1'b0, ST_DBG_FORCE = 1'b1} state_e;
  // 2'b10 is the only size code that is never legal
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return size == SIZE_WORD ? addr_lo != 2'b00 :
           size == SIZE_HALF ? addr_lo[0] : size != SIZE_BYTE;
  endfunction
endpackage

// File: rtl/dmem_align_check.sv
// dmem_align_check: flags an illegal access size or a misaligned byte address.
module dmem_align_check
  import dmem_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic       illegal_o
);
  assign illegal_o = misaligned(size_i, addr_lo_i);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory read/write ports between the CPU (fixed priority) and the
// debug unit, forcing a debug grant after MAX_WAIT lost cycles. DMEM_ARB_DBG_WRITE_EN adds debug writes.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int N_ADDRESS  = 64,
  parameter int NB_ADDRESS = $clog2(N_ADDRESS),
  parameter int MAX_WAIT   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [NB_ADDRESS-1:0] i_cpu_addr,
  input  logic [NB_DATA-1:0]    i_cpu_wdata,
  input  logic [1:0]            i_cpu_size,
  output logic                  o_cpu_gnt,
  output logic                  o_cpu_stall,
  output logic [NB_DATA-1:0]    o_cpu_rdata,
  output logic                  o_cpu_misaligned,
  input  logic                  i_dbg_req,
  input  logic [NB_ADDRESS-1:0] i_dbg_addr,
`ifdef DMEM_ARB_DBG_WRITE_EN
  input  logic                  i_dbg_we,
  input  logic [NB_DATA-1:0]    i_dbg_wdata,
`endif
  output logic                  o_dbg_gnt,
  output logic [NB_DATA-1:0]    o_dbg_rdata,
  output logic                  o_dbg_valid,
  output logic [NB_ADDRESS-1:0] o_mem_r_addr,
  output logic                  o_mem_r_en,
  output logic [1:0]            o_mem_r_addressing,
  output logic [NB_ADDRESS-1:0] o_mem_w_addr,
  output logic [NB_DATA-1:0]    o_mem_w_data,
  output logic                  o_mem_w_en,
  output logic [1:0]            o_mem_w_addressing,
  input  logic [NB_DATA-1:0]    i_mem_r_data
);
  localparam int NB_CNT = $clog2(MAX_WAIT + 1);
  state_e              state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0]  dbg_rdata_q, dbg_rdata_d;
  logic                dbg_valid_q, dbg_valid_d;
  logic                illegal, dbg_win, dbg_lost, cpu_ok, cpu_ld, cpu_st, dbg_rd, dbg_wr, dbg_we;
  logic [NB_DATA-1:0]  dbg_wdata;
  logic [NB_ADDRESS-1:0] dbg_addr_al;
`ifdef DMEM_ARB_DBG_WRITE_EN
  assign dbg_we    = i_dbg_we;
  assign dbg_wdata = i_dbg_wdata;
`else
  assign dbg_we    = 1'b0;
  assign dbg_wdata = '0;
`endif
  dmem_align_check u_align (
    .size_i   (i_cpu_size),
    .addr_lo_i(i_cpu_addr[1:0]),
    .illegal_o(illegal)
  );
  always_comb begin
    dbg_win  = i_dbg_req & ((state_q == ST_DBG_FORCE) | ~i_cpu_req);
    dbg_lost = i_dbg_req & ~dbg_win;
    cnt_d    = dbg_lost ? cnt_q + NB_CNT'(1) : '0;
    state_d  = dbg_lost && cnt_d == NB_CNT'(MAX_WAIT) ? ST_DBG_FORCE : ST_CPU_PRIO;
  end
  // grants are masked while reset is held so nothing reaches memory in a reset cycle
  assign o_cpu_gnt        = i_cpu_req & ~dbg_win & ~i_rst;
  assign o_dbg_gnt        = dbg_win & ~i_rst;
  assign o_cpu_stall      = i_cpu_req & ~o_cpu_gnt;
  assign o_cpu_misaligned = o_cpu_gnt & illegal;
  assign cpu_ok           = o_cpu_gnt & ~illegal;
  assign cpu_ld           = cpu_ok & ~i_cpu_we;
  assign cpu_st           = cpu_ok & i_cpu_we;
  assign dbg_rd           = o_dbg_gnt & ~dbg_we;
  assign dbg_wr           = o_dbg_gnt & dbg_we;
  assign dbg_addr_al      = i_dbg_addr & ~NB_ADDRESS'(3);
  always_comb begin
    o_cpu_rdata        = cpu_ld ? i_mem_r_data : '0;
    o_mem_r_en         = cpu_ld | dbg_rd;
    o_mem_r_addr       = cpu_ld ? i_cpu_addr : dbg_rd ? dbg_addr_al : '0;
    o_mem_r_addressing = cpu_ld ? i_cpu_size : SIZE_WORD;
    o_mem_w_en         = cpu_st | dbg_wr;
    o_mem_w_addr       = cpu_st ? i_cpu_addr : dbg_wr ? dbg_addr_al : '0;
    o_mem_w_data       = cpu_st ? i_cpu_wdata : dbg_wr ? dbg_wdata : '0;
    o_mem_w_addressing = cpu_st ? i_cpu_size : SIZE_WORD;
    dbg_rdata_d        = dbg_rd ? i_mem_r_data : dbg_rdata_q;
    dbg_valid_d        = dbg_rd;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q     <= ST_CPU_PRIO;
      cnt_q       <= '0;
      dbg_rdata_q <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dbg_rdata_q <= dbg_rdata_d;
      dbg_valid_q <= dbg_valid_d;
    end
  assign o_dbg_rdata = dbg_rdata_q;
  assign o_dbg_valid = dbg_valid_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random traffic against a cycle-level reference of the arbitration rules.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;
  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_cpu_req = 0, i_cpu_we = 0, i_dbg_req = 0;
  logic [5:0]  i_cpu_addr = 0, i_dbg_addr = 0;
  logic [31:0] i_cpu_wdata = 0;
  logic [1:0]  i_cpu_size = 0;
  logic        o_cpu_gnt, o_cpu_stall, o_cpu_misaligned, o_dbg_gnt, o_dbg_valid;
  logic [31:0] o_cpu_rdata, o_dbg_rdata, o_mem_w_data, i_mem_r_data;
  logic [5:0]  o_mem_r_addr, o_mem_w_addr;
  logic        o_mem_r_en, o_mem_w_en;
  logic [1:0]  o_mem_r_addressing, o_mem_w_addressing;
  logic        dw = 1'b0;
  logic [31:0] dwd = 0;
  int          total = 0, bad = 0, streak = 0;
  logic        exp_valid = 1'b0, seed_mem = 1'b1;
  logic [31:0] exp_rdata = 0;
  logic [7:0]  mem [64];
  logic [7:0]  ref_mem [64];

  dmem_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .i_cpu_size(i_cpu_size),
    .o_cpu_gnt(o_cpu_gnt), .o_cpu_stall(o_cpu_stall), .o_cpu_rdata(o_cpu_rdata),
    .o_cpu_misaligned(o_cpu_misaligned),
    .i_dbg_req(i_dbg_req), .i_dbg_addr(i_dbg_addr),
`ifdef DMEM_ARB_DBG_WRITE_EN
    .i_dbg_we(dw), .i_dbg_wdata(dwd),
`endif
    .o_dbg_gnt(o_dbg_gnt), .o_dbg_rdata(o_dbg_rdata), .o_dbg_valid(o_dbg_valid),
    .o_mem_r_addr(o_mem_r_addr), .o_mem_r_en(o_mem_r_en), .o_mem_r_addressing(o_mem_r_addressing),
    .o_mem_w_addr(o_mem_w_addr), .o_mem_w_data(o_mem_w_data), .o_mem_w_en(o_mem_w_en),
    .o_mem_w_addressing(o_mem_w_addressing),
    .i_mem_r_data(i_mem_r_data)
  );

  always #5 i_clk = ~i_clk;

  function automatic int nb(input logic [1:0] s);
    return s == 2'b00 ? 4 : s == 2'b01 ? 2 : 1;
  endfunction

  function automatic logic [31:0] rd(input logic [7:0] m [64], input logic [5:0] a, input logic [1:0] s);
    logic [31:0] v;
    v = 0;
    for (int k = 0; k < 4; k++) if (k < nb(s)) v[8*k +: 8] = m[6'(a + k)];
    return v;
  endfunction

  // byte-addressed little-endian memory: asynchronous read, write at posedge
  always_comb i_mem_r_data = rd(mem, o_mem_r_addr, o_mem_r_addressing);
  always @(posedge i_clk) begin
    if (seed_mem) for (int k = 0; k < 64; k++) mem[k] <= 8'(k * 37 + 5);
    else if (o_mem_w_en)
      for (int k = 0; k < 4; k++)
        if (k < nb(o_mem_w_addressing)) mem[6'(o_mem_w_addr + k)] <= o_mem_w_data[8*k +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_wr(input logic [5:0] a, input logic [1:0] s, input logic [31:0] d);
    for (int k = 0; k < 4; k++) if (k < nb(s)) ref_mem[6'(a + k)] = d[8*k +: 8];
  endtask

  task automatic step(input logic rs, input logic cr, input logic cw, input logic [1:0] cs,
                      input logic [5:0] ca, input logic [31:0] cd, input logic dr, input logic [5:0] da);
    logic ill, gd, gc, ld, st, drd, dwr;
    logic [5:0] al;
    i_rst = rs; i_cpu_req = cr; i_cpu_we = cw; i_cpu_size = cs; i_cpu_addr = ca;
    i_cpu_wdata = cd; i_dbg_req = dr; i_dbg_addr = da;
    ill = cs == 2'b10 || (cs == 2'b00 && ca[1:0] != 2'b00) || (cs == 2'b01 && ca[0]);
    gd  = !rs && dr && (!cr || streak == MAX_WAIT);
    gc  = !rs && cr && !gd;
    ld  = gc && !ill && !cw;
    st  = gc && !ill && cw;
    drd = gd && !dw;
    dwr = gd && dw;
    al  = {da[5:2], 2'b00};
    if (rs) begin exp_valid = 1'b0; exp_rdata = 0; end
    @(negedge i_clk);
    chk("cpu_gnt", o_cpu_gnt, gc);
    chk("dbg_gnt", o_dbg_gnt, gd);
    chk("cpu_stall", o_cpu_stall, cr && !gc);
    chk("cpu_misaligned", o_cpu_misaligned, gc && ill);
    chk("cpu_rdata", o_cpu_rdata, ld ? rd(ref_mem, ca, cs) : 0);
    chk("r_en", o_mem_r_en, ld || drd);
    chk("r_addr", o_mem_r_addr, ld ? ca : drd ? al : 6'd0);
    chk("r_addressing", o_mem_r_addressing, ld ? cs : 2'b00);
    chk("w_en", o_mem_w_en, st || dwr);
    chk("w_addr", o_mem_w_addr, st ? ca : dwr ? al : 6'd0);
    chk("w_data", o_mem_w_data, st ? cd : dwr ? dwd : 0);
    chk("w_addressing", o_mem_w_addressing, st ? cs : 2'b00);
    chk("dbg_valid", o_dbg_valid, exp_valid);
    chk("dbg_rdata", o_dbg_rdata, exp_rdata);
    if (drd) exp_rdata = rd(ref_mem, al, 2'b00);
    exp_valid = drd;
    if (st) ref_wr(ca, cs, cd);
    if (dwr) ref_wr(al, 2'b00, dwd);
    streak = (dr && !gd && !rs) ? streak + 1 : 0;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [5:0] a;
    for (int k = 0; k < 64; k++) ref_mem[k] = 8'(k * 37 + 5);
    #1;
    step(1, 0, 0, 2'b00, 6'h00, 0, 0, 6'h00);
    step(1, 0, 0, 2'b00, 6'h00, 0, 0, 6'h00);
    seed_mem = 1'b0;
    // CPU-only traffic
    step(0, 1, 1, 2'b00, 6'h08, 32'hDEADBEEF, 0, 6'h00);
    step(0, 1, 0, 2'b00, 6'h08, 0, 0, 6'h00);
    step(0, 1, 0, 2'b01, 6'h08, 0, 0, 6'h00);
    step(0, 1, 0, 2'b11, 6'h0B, 0, 0, 6'h00);
    // debug only, unaligned address folds to the word
    step(0, 0, 0, 2'b00, 6'h00, 0, 1, 6'h0B);
    step(0, 0, 0, 2'b00, 6'h00, 0, 0, 6'h00);
    step(0, 0, 0, 2'b00, 6'h00, 0, 0, 6'h00);
    // contention: 4 denials, forced grant, then a fresh count
    repeat (10) step(0, 1, 0, 2'b00, 6'h04, 0, 1, 6'h10);
    // illegal CPU accesses
    step(0, 1, 0, 2'b00, 6'h06, 0, 0, 6'h00);
    step(0, 1, 1, 2'b00, 6'h06, 32'h11111111, 0, 6'h00);
    step(0, 1, 0, 2'b10, 6'h00, 0, 0, 6'h00);
    step(0, 1, 1, 2'b10, 6'h00, 32'h22222222, 0, 6'h00);
    step(0, 1, 1, 2'b01, 6'h03, 32'h33333333, 0, 6'h00);
    // debug drops while forced
    repeat (4) step(0, 1, 0, 2'b00, 6'h08, 0, 1, 6'h20);
    step(0, 1, 0, 2'b00, 6'h08, 0, 0, 6'h20);
    repeat (3) step(0, 1, 0, 2'b00, 6'h08, 0, 1, 6'h20);
    // reset landing on a debug grant cycle and on a store
    step(0, 0, 0, 2'b00, 6'h00, 0, 1, 6'h08);
    step(1, 0, 0, 2'b00, 6'h00, 0, 1, 6'h0C);
    step(1, 1, 1, 2'b00, 6'h08, 32'hCAFEF00D, 0, 6'h00);
    step(0, 1, 0, 2'b00, 6'h08, 0, 1, 6'h0C);
    step(0, 0, 0, 2'b00, 6'h00, 0, 0, 6'h00);
`ifdef DMEM_ARB_DBG_WRITE_EN
    dw = 1'b1; dwd = 32'h12345678;
    step(0, 0, 0, 2'b00, 6'h00, 0, 1, 6'h10);
    dw = 1'b0; dwd = 0;
    step(0, 1, 0, 2'b00, 6'h10, 0, 0, 6'h00);
`endif
    repeat (500) begin
      a = 6'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
           2'($urandom), a, $urandom, 1'($urandom), 6'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sits between the pipeline MEM stage, the debug unit and the byte-addressed data memory.
- Shares the memory's single read port and single write port between two requesters, with fixed CPU priority.
- Includes a starvation counter that forces a debug grant after MAX_WAIT lost cycles.
- Checks CPU access size and alignment, and suppresses illegal accesses before they reach memory.

Parameters:
- NB_DATA, 32, data width.
- N_ADDRESS, 64, memory depth in bytes.
- NB_ADDRESS, $clog2(N_ADDRESS), byte address width.
- MAX_WAIT, 4, consecutive lost debug cycles before a forced debug grant (≥1).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_cpu_req  in  1  CPU access request
- i_cpu_we  in  1  1=store, 0=load
- i_cpu_addr  in  NB_ADDRESS  CPU byte address
- i_cpu_wdata  in  NB_DATA  store data
- i_cpu_size  in  2  00 word, 01 half, 11 byte, 10 illegal
- o_cpu_gnt  out  1  CPU owns memory this cycle
- o_cpu_stall  out  1  i_cpu_req & ~o_cpu_gnt
- o_cpu_rdata  out  NB_DATA  i_mem_r_data when CPU load granted, else 0
- o_cpu_misaligned  out  1  granted CPU access illegal/misaligned; access suppressed
- i_dbg_req  in  1  debug read request (word)
- i_dbg_addr  in  NB_ADDRESS  debug byte address, word-aligned
- o_dbg_gnt  out  1  debug owns memory this cycle
- o_dbg_rdata  out  NB_DATA  registered debug read data
- o_dbg_valid  out  1  o_dbg_rdata valid, single-cycle pulse
- o_mem_r_addr / o_mem_r_en / o_mem_r_addressing  out  NB_ADDRESS/1/2  memory read port
- o_mem_w_addr / o_mem_w_data / o_mem_w_en / o_mem_w_addressing  out  NB_ADDRESS/NB_DATA/1/2  memory write port
- i_mem_r_data  in  NB_DATA  memory asynchronous read data

Behaviour:
- **Arbitration:** combinational, decided each cycle from the requests and the registered state. The winner drives the memory ports in the same cycle. Reads are asynchronous and complete in that cycle; writes commit at the next posedge.
- **FSM states:** ST_CPU_PRIO (reset state) and ST_DBG_FORCE.
- **ST_CPU_PRIO:**
  - CPU wins if i_cpu_req.
  - Otherwise debug wins if i_dbg_req.
- **ST_DBG_FORCE:**
  - Debug wins if i_dbg_req; CPU stalls.
  - Otherwise CPU wins if requesting.
- **Starvation counter** (width $clog2(MAX_WAIT+1)):
  - Increments on each posedge with i_dbg_req & ~o_dbg_gnt.
  - Cleared on a debug grant or when i_dbg_req=0.
  - Transition to ST_DBG_FORCE when it would reach MAX_WAIT.
  - Leave ST_DBG_FORCE (back to ST_CPU_PRIO, counter 0) after the debug grant, or if i_dbg_req drops.
- **Debug read:**
  - Word read; o_mem_r_addressing=00.
  - o_dbg_rdata is loaded from i_mem_r_data at the posedge ending the grant cycle.
  - o_dbg_valid=1 during the following cycle only.
  - Debug address bits [1:0] are ignored and treated as 0.
- **CPU legality:**
  - size 10 is illegal.
  - word requires addr[1:0]=00; half requires addr[0]=0.
  - An illegal access that is granted: o_cpu_misaligned=1, no memory enable asserted, o_cpu_rdata=0, o_cpu_gnt=1 (no stall).
- **CPU load:** o_mem_r_en=1 with o_mem_r_addressing=i_cpu_size. **CPU store:** o_mem_w_en=1 with o_mem_w_addressing=i_cpu_size.
- **Idle / loser outputs:** all memory enables 0, addresses and data 0; o_cpu_rdata=0 unless a CPU load is granted.
- **Reset values:** state ST_CPU_PRIO, counter 0, o_dbg_rdata 0, o_dbg_valid 0. While i_rst=1, every grant and memory enable is forced to 0.
- **Reset mid-operation:** an in-flight debug read is dropped (no o_dbg_valid). Any write presented in a reset cycle is not issued.

Optional Feature:
- **DMEM_ARB_DBG_WRITE_EN defined:** adds ports i_dbg_we (1) and i_dbg_wdata (NB_DATA).
  - A granted debug write drives the write port with word addressing.
  - No o_dbg_valid pulse is generated for a debug write.
- **Undefined:** the ports are absent and the debug port is read-only.

Decomposition:
- Shared package dmem_pkg holds:
  - Size encodings SIZE_WORD=2'b00, SIZE_HALF=2'b01, SIZE_BYTE=2'b11.
  - FSM state encodings.
  - Alignment-check function.
- Sub-module dmem_align_check (combinational: size, addr → illegal) is natural. It is reused by the load/store unit.

Test Plan:
- CPU-only traffic:
  - Store word 0xDEADBEEF @0x08, then load word @0x08 → o_cpu_rdata=0xDEADBEEF, o_cpu_stall=0.
  - Load half @0x08 → o_mem_r_addressing=01.
- Debug only:
  - req @0x0B → o_mem_r_addr=0x08.
  - o_dbg_valid pulses one cycle later with 0xDEADBEEF.
- Contention with CPU requesting continuously, MAX_WAIT=4:
  - Debug is denied 4 cycles.
  - 5th cycle o_dbg_gnt=1, o_cpu_stall=1.
  - Next cycle CPU granted again, counter 0.
- Misalignment:
  - word @0x06 → o_cpu_misaligned=1, o_mem_r_en=0, o_mem_w_en=0.
  - size 10 @0x00 → same response.
- Debug drops req while in ST_DBG_FORCE → state returns to ST_CPU_PRIO; CPU granted next cycle.
- Assert i_rst in a debug grant cycle → no o_dbg_valid, o_dbg_rdata=0, state ST_CPU_PRIO.
  - With DMEM_ARB_DBG_WRITE_EN: debug write 0x12345678 @0x10, then CPU load @0x10 → 0x12345678.
